// File: rtl/int_sched.sv
// Fixed-priority interrupt scheduler: latches request edges, masks them and
// steps the control unit into one handler at a time (freeze PC, call, wait for return).
module int_sched #(
   parameter int              NIRQ     = 4,
   parameter int              VW       = 16,
   parameter logic [VW-1:0]   VBASE    = VW'(16'h0010),
   parameter int              VSTEP    = 2,
   parameter logic [NIRQ-1:0] MASK_RST = '1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [NIRQ-1:0] IRQ,
   input  logic            ret,
   input  logic            MaskWE,
   input  logic [NIRQ-1:0] MaskIn,
   output logic            interrupt,
   output logic            CallInt,
   output logic [VW-1:0]   Vector,
   output logic [NIRQ-1:0] Pending,
   output logic [NIRQ-1:0] Mask,
   output logic            Busy
);

   localparam int SW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      CALL,
      SERVICE
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [NIRQ-1:0] irq_d;
   logic [NIRQ-1:0] rise;
   logic [NIRQ-1:0] elig;
   logic [NIRQ-1:0] clr;
   logic [SW-1:0]   win;
   logic [SW-1:0]   sel;
   logic            take;

   assign rise = IRQ & ~irq_d;
   assign elig = Pending & Mask;
   assign take = (state == IDLE) && (elig != '0);
   assign clr  = (state == HOLD) ? (NIRQ'(1) << sel) : '0;

   // Lowest set index of the eligible vector wins.
   always_comb begin
      win = '0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (elig[i]) begin
            win = SW'(i);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (take) state_next = HOLD;
         HOLD:    state_next = CALL;
         CALL:    state_next = SERVICE;
         SERVICE: if (ret) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A fresh edge on the line being cleared in HOLD keeps it pending.
   always_ff @(posedge CLK) begin
      if (RST) begin
         irq_d   <= '0;
         Pending <= '0;
         Mask    <= MASK_RST;
      end else begin
         irq_d   <= IRQ;
         Pending <= (Pending & ~clr) | rise;
         if (MaskWE) begin
            Mask <= MaskIn;
         end
      end
   end

   // Selection and its vector stay put until the next handler is chosen.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sel    <= '0;
         Vector <= VBASE;
      end else if (take) begin
         sel    <= win;
         Vector <= VBASE + VW'(win) * VW'(VSTEP);
      end
   end

   assign interrupt = (state == HOLD) || (state == CALL);
   assign CallInt   = (state == CALL);
   assign Busy      = (state != IDLE);

endmodule

// File: tb/tb_int_sched.sv
// Directed self-checking bench for int_sched: a vector table for the main flows
// plus hand-written sequences for held levels, reset mid-entry and re-arm in HOLD.
module tb_int_sched;

   logic        CLK;
   logic        RST;
   logic [3:0]  IRQ;
   logic        ret;
   logic        MaskWE;
   logic [3:0]  MaskIn;
   logic        interrupt;
   logic        CallInt;
   logic [15:0] Vector;
   logic [3:0]  Pending;
   logic [3:0]  Mask;
   logic        Busy;

   int n_cmp = 0;
   int n_err = 0;

   int_sched dut (
      .CLK       (CLK),
      .RST       (RST),
      .IRQ       (IRQ),
      .ret       (ret),
      .MaskWE    (MaskWE),
      .MaskIn    (MaskIn),
      .interrupt (interrupt),
      .CallInt   (CallInt),
      .Vector    (Vector),
      .Pending   (Pending),
      .Mask      (Mask),
      .Busy      (Busy)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct packed {
      logic        rst;
      logic [3:0]  irq;
      logic        ret;
      logic        we;
      logic [3:0]  min;
      logic        e_int;
      logic        e_call;
      logic        e_busy;
      logic [15:0] e_vec;
      logic [3:0]  e_pend;
      logic [3:0]  e_mask;
   } vec_t;

   vec_t tbl [25];

   task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge, outputs are read there too.
   task automatic applyStimulus(input logic rst, input logic [3:0] irq, input logic r,
                                input logic we, input logic [3:0] min);
      RST    = rst;
      IRQ    = irq;
      ret    = r;
      MaskWE = we;
      MaskIn = min;
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic e_int, input logic e_call,
                              input logic e_busy, input logic [15:0] e_vec,
                              input logic [3:0] e_pend, input logic [3:0] e_mask);
      compareVal({tag, ".interrupt"}, 32'(interrupt), 32'(e_int));
      compareVal({tag, ".CallInt"},   32'(CallInt),   32'(e_call));
      compareVal({tag, ".Busy"},      32'(Busy),      32'(e_busy));
      compareVal({tag, ".Vector"},    32'(Vector),    32'(e_vec));
      compareVal({tag, ".Pending"},   32'(Pending),   32'(e_pend));
      compareVal({tag, ".Mask"},      32'(Mask),      32'(e_mask));
   endtask

   initial begin
      int calls;

      RST    = 1'b1;
      IRQ    = 4'b0000;
      ret    = 1'b0;
      MaskWE = 1'b0;
      MaskIn = 4'hF;

      //           rst irq     ret we  min      int  call busy vec       pend     mask
      tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0010, 4'b0000, 4'hF};
      tbl[1]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0010, 4'b0000, 4'hF};
      tbl[2]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0010, 4'b0100, 4'hF};
      tbl[3]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 16'h0014, 4'b0100, 4'hF};
      tbl[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 16'h0014, 4'b0000, 4'hF};
      tbl[5]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0014, 4'b0000, 4'hF};
      tbl[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0014, 4'b0000, 4'hF};
      tbl[7]  = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0014, 4'b1010, 4'hF};
      tbl[8]  = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 16'h0012, 4'b1010, 4'hF};
      tbl[9]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 16'h0012, 4'b1000, 4'hF};
      tbl[10] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0012, 4'b1000, 4'hF};
      tbl[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0012, 4'b1000, 4'hF};
      tbl[12] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 16'h0016, 4'b1000, 4'hF};
      tbl[13] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 16'h0016, 4'b0000, 4'hF};
      tbl[14] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0016, 4'b0000, 4'hF};
      tbl[15] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0016, 4'b0000, 4'hF};
      tbl[16] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 16'h0016, 4'b0000, 4'hE};
      tbl[17] = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0016, 4'b0001, 4'hE};
      tbl[18] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0016, 4'b0001, 4'hE};
      tbl[19] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0016, 4'b0001, 4'hF};
      tbl[20] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 16'h0010, 4'b0001, 4'hF};
      tbl[21] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 16'h0010, 4'b0000, 4'hF};
      tbl[22] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0010, 4'b0000, 4'hF};
      tbl[23] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0010, 4'b0000, 4'hF};
      tbl[24] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0010, 4'b0000, 4'hF};

      for (int i = 0; i < 25; i++) begin
         applyStimulus(tbl[i].rst, tbl[i].irq, tbl[i].ret, tbl[i].we, tbl[i].min);
         checkOutput($sformatf("vec%0d", i), tbl[i].e_int, tbl[i].e_call, tbl[i].e_busy,
                     tbl[i].e_vec, tbl[i].e_pend, tbl[i].e_mask);
      end

      // IRQ[1] held high for 20 cycles gives one service; ret during HOLD is ignored.
      calls = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 4'b0010, (i == 2) || (i == 6), 1'b0, 4'h0);
         if (CallInt) calls++;
         if (i == 1) compareVal("held.hold_int", 32'(interrupt), 32'd1);
         if (i == 2) compareVal("held.ret_in_hold", 32'(CallInt), 32'd1);
      end
      compareVal("held.calls", 32'(calls), 32'd1);
      compareVal("held.busy", 32'(Busy), 32'd0);
      compareVal("held.pend", 32'(Pending), 32'd0);
      compareVal("held.vec", 32'(Vector), 32'h0012);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);

      // Reset during CALL abandons the entry and clears the leftover pending line.
      applyStimulus(1'b0, 4'b1010, 1'b0, 1'b0, 4'h0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
      compareVal("rst.pre_call", 32'(CallInt), 32'd1);
      compareVal("rst.pre_pend", 32'(Pending), 32'b1000);
      applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, 4'h0);
      checkOutput("rst.after", 1'b0, 1'b0, 1'b0, 16'h0010, 4'b0000, 4'hF);
      applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0, 4'h0);
      compareVal("rst.high_out_of_reset", 32'(Pending), 32'b0100);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 4'h0);
      compareVal("rst.recover_idle", 32'(Busy), 32'd0);

      // Second IRQ[2] edge arriving in HOLD survives the clear and is served again.
      applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0, 4'h0);
      compareVal("rearm.pend0", 32'(Pending), 32'b0100);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
      checkOutput("rearm.hold", 1'b1, 1'b0, 1'b1, 16'h0014, 4'b0100, 4'hF);
      applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0, 4'h0);
      checkOutput("rearm.call", 1'b1, 1'b1, 1'b1, 16'h0014, 4'b0100, 4'hF);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 4'h0);
      checkOutput("rearm.idle", 1'b0, 1'b0, 1'b0, 16'h0014, 4'b0100, 4'hF);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
      checkOutput("rearm.hold2", 1'b1, 1'b0, 1'b1, 16'h0014, 4'b0100, 4'hF);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
      checkOutput("rearm.call2", 1'b1, 1'b1, 1'b1, 16'h0014, 4'b0000, 4'hF);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 4'h0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 4'h0);
      compareVal("rearm.done", 32'(Busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/int_sched.md
Name: int_sched

Overview:
- Interrupt scheduler in front of the microcode control unit.
- Latches rising edges on NIRQ request lines, masks them, and picks one by fixed priority.
- Sequences entry to the selected handler: freezes the PC (interrupt), fires one call cycle (CallInt) with the handler vector, then holds off further entries until the handler's return (ret) is seen.
- No nesting: one handler in service at a time.

Parameters:
- NIRQ, 4, number of request lines (2..8).
- VW, 16, vector address width.
- VBASE, 16'h0010, vector of IRQ[0].
- VSTEP, 2, address spacing between consecutive vectors.
- MASK_RST, all ones, Mask value after reset.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  synchronous active-high reset.
- IRQ  in  NIRQ  level request lines, already synchronous to CLK; rising edge = event.
- ret  in  1  return strobe from control unit; ends service.
- MaskWE  in  1  Mask write enable.
- MaskIn  in  NIRQ  new Mask value.
- interrupt  out  1  PC increment inhibit to control unit.
- CallInt  out  1  one-cycle forced call / bus write to control unit.
- Vector  out  VW  handler address for the selected request.
- Pending  out  NIRQ  latched unserviced events.
- Mask  out  NIRQ  enable per line (1 = enabled).
- Busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (RST=1 at an edge), taking effect at that edge:
  - state=IDLE, Pending=0, Mask=MASK_RST, IRQ history=0, selected id=0.
  - interrupt=0, CallInt=0, Busy=0, Vector=VBASE.
  - RST overrides everything, including mid-sequence; a handler in progress is abandoned.
- Edge detection:
  - irq_d<=IRQ every edge.
  - Pending[i] sets at the edge where IRQ[i]=1 and irq_d[i]=0.
  - A level held high does not re-trigger.
  - A line already high when coming out of reset counts as an edge on the first cycle.
- Mask: Mask<=MaskIn on an edge with MaskWE=1, in any state.
- Eligibility:
  - elig = Pending & Mask.
  - The winner is the lowest set index of elig.
  - A masked pending bit stays pending and becomes eligible once unmasked.
- FSM, with outputs decoded from the registered state:
  - IDLE: interrupt=0, CallInt=0. If elig!=0, latch sel=winner and go to HOLD. Otherwise stay.
  - HOLD: one cycle, interrupt=1, CallInt=0. This lets the instruction in flight finish with PCpp suppressed. Clear Pending[sel]; go to CALL.
  - CALL: one cycle, interrupt=1, CallInt=1. Go to SERVICE.
  - SERVICE: interrupt=0, CallInt=0. Stay until ret=1, then go to IDLE. A new winner is evaluated in the following IDLE cycle, so there is a minimum 1 IDLE cycle between services.
- Vector = VBASE + sel*VSTEP, VW-bit wraparound, registered with sel. Held stable from HOLD through SERVICE and after returning to IDLE until the next selection.
- Latency: with the edge captured at clock k, HOLD starts at k+1, CALL at k+2, SERVICE at k+3.
- Simultaneous events:
  - New edge on Pending[sel] in the same cycle it is cleared: set wins, and the bit stays pending.
  - Several lines rising at once: all latch; served in index order, one per service.
  - ret in IDLE/HOLD/CALL: ignored.
  - ret in the same cycle an edge arrives: both take effect.
  - MaskWE clearing Mask[sel] after selection does not cancel the committed sequence.
- Busy = (state != IDLE).

Test Plan:
- Reset with IRQ=4'b0000 -> Pending=0, Mask=4'hF, interrupt=CallInt=Busy=0. Pulse IRQ[2] -> Pending=4'b0100. Then HOLD (interrupt=1), then CALL (interrupt=1, CallInt=1, Vector=16'h0014), then SERVICE; Pending=0 after HOLD.
- IRQ=4'b1010 rising together -> IRQ[1] served first (Vector=16'h0012) and Pending=4'b1000 stays. ret pulse -> 1 IDLE cycle, then IRQ[3] sequence with Vector=16'h0016.
- MaskIn=4'b1110, MaskWE=1, then pulse IRQ[0] -> Pending=4'b0001, no HOLD. Write Mask=4'hF -> sequence starts the next cycle, Vector=16'h0010.
- IRQ[1] held high 20 cycles -> exactly one service. ret in IDLE or HOLD -> no state change.
- RST asserted during CALL with Pending=4'b1000 -> next cycle IDLE, Pending=0, interrupt=0, CallInt=0.
- Second edge on IRQ[2] in the HOLD cycle of an IRQ[2] entry -> Pending[2]=1 after HOLD. After ret, a second IRQ[2] service follows.
